ram_port_arbiter: RTL

Shares the single-port instruction/data RAM between the instruction-fetch port and the load/store data port of the core. It arbitrates round-robin, translates CPU byte addresses into RAM-relative addresses, and rejects out-of-window or misaligned accesses without touching the RAM. It sits between the core's two memory ports and the RAM, which has fixed one-cycle read latency. The core sees a request/grant/response handshake with exactly one cycle from grant to response.

---
 rtl/ram_port_arbiter_if.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - core fetch/data ports and RAM port bundle for ram_port_arbiter
//   if_*  : instruction-fetch request/grant/response
//   d_*   : load/store request/grant/response
//   mem_* : single-port RAM strobe/address/data, one-cycle read latency
//   slave  modport: the arbiter's view
//   master modport: the core/RAM side's view
interface ram_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_rd, mem_wr, mem_addr, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_be, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_rd, mem_wr, mem_addr, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM between fetch and data ports
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : ram_port_arbiter_if.slave (fetch port, data port, RAM port)
module ram_port_arbiter #(
  parameter logic [31:0] BASE = 32'h0000_2000,
  parameter logic [31:0] SIZE = 32'h0000_4000
) (
  input logic         clk,
  input logic         rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_FETCH = 1'b0,
    LAST_DATA  = 1'b1
  } last_t;

  last_t       last_q;
  last_t       last_d;

  logic        grant_f;
  logic        grant_d;
  logic        any_gnt;
  logic        sel_store;
  logic        legal;
  logic [31:0] sel_addr;
  logic [31:0] offset;

  // Response registers: what was granted in the previous cycle.
  logic        resp_valid;
  logic        resp_port;      // 1 = data port, 0 = fetch port
  logic        resp_err;
  logic        resp_is_store;

  logic        resp_live;
  logic        rdata_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q        <= LAST_FETCH;
      resp_valid    <= 1'b0;
      resp_port     <= 1'b0;
      resp_err      <= 1'b0;
      resp_is_store <= 1'b0;
    end else begin
      last_q        <= last_d;
      resp_valid    <= any_gnt;
      resp_port     <= grant_d;
      resp_err      <= any_gnt & ~legal;
      resp_is_store <= sel_store;
    end
  end

  always_comb begin
    grant_f       = 1'b0;
    grant_d       = 1'b0;
    any_gnt       = 1'b0;
    sel_store     = 1'b0;
    sel_addr      = bus.if_addr;
    offset        = 32'h0;
    legal         = 1'b0;
    last_d        = last_q;

    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_be    = 4'h0;
    bus.mem_wdata = 32'h0;

    if (!rst) begin
      // Data wins unless fetch is also asking and data had the last grant.
      grant_d = bus.d_req & (~bus.if_req | (last_q == LAST_FETCH));
      grant_f = bus.if_req & ~grant_d;
    end
    any_gnt   = grant_f | grant_d;
    sel_store = grant_d & bus.d_we;
    sel_addr  = grant_d ? bus.d_addr : bus.if_addr;

    // Wrapping subtraction folds both window edges into one unsigned compare.
    offset = sel_addr - BASE;
    legal  = (offset < SIZE) && (sel_addr[1:0] == 2'b00);

    if (grant_d) begin
      last_d = LAST_DATA;
    end else if (grant_f) begin
      last_d = LAST_FETCH;
    end

    bus.if_gnt = grant_f;
    bus.d_gnt  = grant_d;

    if (any_gnt && legal) begin
      bus.mem_rd   = ~sel_store;
      bus.mem_wr   = sel_store;
      bus.mem_addr = offset;
      bus.mem_be   = sel_store ? bus.d_be : 4'hF;
      if (sel_store) begin
        bus.mem_wdata = bus.d_wdata;
      end
    end
  end

  // Gating with rst hides a response whose grant preceded reset assertion.
  always_comb begin
    resp_live    = resp_valid & ~rst;
    rdata_ok     = resp_live & ~resp_err & ~resp_is_store;

    bus.if_rvalid = resp_live & ~resp_port;
    bus.d_rvalid  = resp_live & resp_port;
    bus.if_err    = resp_live & ~resp_port & resp_err;
    bus.d_err     = resp_live & resp_port & resp_err;
    bus.if_rdata  = (rdata_ok & ~resp_port) ? bus.mem_rdata : 32'h0;
    bus.d_rdata   = (rdata_ok & resp_port) ? bus.mem_rdata : 32'h0;
  end

endmodule
